// File: rtl/seq_alu_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
package seq_alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_AND  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_MUL  = 3'b011;
   localparam logic [2:0] OP_DIVU = 3'b100;
   localparam logic [2:0] OP_REMU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative shift-add multiplier / restoring divider, one step per enabled cycle.
// The next-state values are exported so the owner can capture the final step's outcome on the same edge.
module seq_muldiv_core #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi_nxt,
   output logic [WIDTH-1:0] lo_nxt
);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mq_q, mq_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic             div_q, div_d;
   logic [WIDTH:0]   shifted, diff, sum;
   logic             ge;

   always_comb begin
      acc_d   = acc_q;
      mq_d    = mq_q;
      opnd_d  = opnd_q;
      div_d   = div_q;
      shifted = '0;
      diff    = '0;
      sum     = '0;
      ge      = 1'b0;
      if (load) begin
         acc_d = '0;
         div_d = is_div;
         if (is_div) begin
            mq_d   = a;
            opnd_d = b;
         end else begin
            mq_d   = b;
            opnd_d = a;
         end
      end else if (step) begin
         if (div_q) begin
            // Divisor 0 makes every step "fit": quotient all-ones, remainder ends as the dividend.
            shifted = {acc_q, mq_q[WIDTH-1]};
            ge      = (shifted >= {1'b0, opnd_q});
            diff    = shifted - {1'b0, opnd_q};
            acc_d   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            mq_d    = {mq_q[WIDTH-2:0], ge};
         end else begin
            sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : '0);
            acc_d = sum[WIDTH:1];
            mq_d  = {sum[0], mq_q[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         acc_q  <= '0;
         mq_q   <= '0;
         opnd_q <= '0;
         div_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         mq_q   <= mq_d;
         opnd_q <= opnd_d;
         div_q  <= div_d;
      end
   end

   assign hi_nxt = acc_d;
   assign lo_nxt = mq_d;

endmodule

// File: rtl/seq_alu.sv
// Handshaked multi-cycle ALU: single-cycle ADD/AND/SUB, iterative MUL/DIVU/REMU
// with Z/N/V status, divide-by-zero and illegal-op flags.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             Z,
   output logic             N,
   output logic             V,
   output logic             dbz,
   output logic             illegal
);

   localparam int unsigned CNTW = $clog2(WIDTH + 1);

   state_t           state_q, state_d;
   logic [CNTW-1:0]  cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic             bz_q, bz_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             z_q, z_d, n_q, n_d, v_q, v_d;
   logic             dbz_q, dbz_d, ill_q, ill_d;

   logic             accept, upd, core_load, core_step;
   logic [WIDTH-1:0] res_new, add_y, sub_y, hi_nxt, lo_nxt;
   logic             v_new, dbz_new, ill_new;

   assign in_ready = reset && (state_q == S_IDLE);
   assign accept   = in_valid && in_ready;
   assign add_y    = a + b;
   assign sub_y    = a - b;

   seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .reset  (reset),
      .load   (core_load),
      .step   (core_step),
      .is_div (op != OP_MUL),
      .a      (a),
      .b      (b),
      .hi_nxt (hi_nxt),
      .lo_nxt (lo_nxt)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      bz_d        = bz_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      z_d         = z_q;
      n_d         = n_q;
      v_d         = v_q;
      dbz_d       = dbz_q;
      ill_d       = ill_q;
      upd         = 1'b0;
      res_new     = '0;
      v_new       = 1'b0;
      dbz_new     = 1'b0;
      ill_new     = 1'b0;
      core_load   = 1'b0;
      core_step   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d = op;
               bz_d = (b == '0);
               unique case (op)
                  OP_ADD: begin
                     upd     = 1'b1;
                     res_new = add_y;
                     v_new   = (a[WIDTH-1] == b[WIDTH-1]) && (add_y[WIDTH-1] != a[WIDTH-1]);
                  end
                  OP_AND: begin
                     upd     = 1'b1;
                     res_new = a & b;
                  end
                  OP_SUB: begin
                     upd     = 1'b1;
                     res_new = sub_y;
                     v_new   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_y[WIDTH-1] != a[WIDTH-1]);
                  end
                  OP_MUL, OP_DIVU, OP_REMU: begin
                     core_load = 1'b1;
                     cnt_d     = CNTW'(WIDTH);
                     state_d   = S_BUSY;
                  end
                  default: begin
                     upd     = 1'b1;
                     ill_new = 1'b1;
                  end
               endcase
            end
         end
         S_BUSY: begin
            core_step = 1'b1;
            cnt_d     = cnt_q - CNTW'(1);
            if (cnt_q == CNTW'(1)) begin
               upd     = 1'b1;
               dbz_new = bz_q && (op_q != OP_MUL);
               unique case (op_q)
                  OP_MUL: begin
                     res_new = lo_nxt;
                     v_new   = (hi_nxt != '0);
                  end
                  OP_DIVU: res_new = lo_nxt;
                  default: res_new = hi_nxt;
               endcase
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (upd) begin
         state_d     = S_DONE;
         out_valid_d = 1'b1;
         result_d    = res_new;
         z_d         = (res_new == '0);
         n_d         = res_new[WIDTH-1];
         v_d         = v_new;
         dbz_d       = dbz_new;
         ill_d       = ill_new;
      end

      // Flush wins over a completion on the same edge: the result registers keep their old contents.
      if (flush) begin
         state_d     = S_IDLE;
         out_valid_d = 1'b0;
         result_d    = result_q;
         z_d         = z_q;
         n_d         = n_q;
         v_d         = v_q;
         dbz_d       = dbz_q;
         ill_d       = ill_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         op_q        <= '0;
         bz_q        <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         z_q         <= 1'b0;
         n_q         <= 1'b0;
         v_q         <= 1'b0;
         dbz_q       <= 1'b0;
         ill_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         bz_q        <= bz_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         z_q         <= z_d;
         n_q         <= n_d;
         v_q         <= v_d;
         dbz_q       <= dbz_d;
         ill_q       <= ill_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign Z         = z_q;
   assign N         = n_q;
   assign V         = v_q;
   assign dbz       = dbz_q;
   assign illegal   = ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized bench for seq_alu (WIDTH=16) against an arithmetic reference model.
module tb_seq_alu;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
   logic [15:0] a, b, result;
   logic [2:0]  op;
   logic        Z, N, V, dbz, illegal;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   typedef struct {
      logic [15:0] res;
      logic        v;
      logic        dbz;
      logic        ill;
      int          lat;
   } exp_t;

   seq_alu #(.WIDTH(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .Z         (Z),
      .N         (N),
      .V         (V),
      .dbz       (dbz),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
      exp_t   e;
      int     sx, sy, s;
      longint p;
      sx = $signed(x);
      sy = $signed(y);
      e.res = '0; e.v = 1'b0; e.dbz = 1'b0; e.ill = 1'b0; e.lat = 1;
      case (o)
         3'd0: begin s = sx + sy; e.res = 16'(s); e.v = (s > 32767) || (s < -32768); end
         3'd1: e.res = x & y;
         3'd2: begin s = sx - sy; e.res = 16'(s); e.v = (s > 32767) || (s < -32768); end
         3'd3: begin
            p = longint'(x) * longint'(y);
            e.res = 16'(p); e.v = (p >= 65536); e.lat = 17;
         end
         3'd4: begin
            e.lat = 17;
            if (y == 0) begin e.res = 16'hFFFF; e.dbz = 1'b1; end
            else e.res = 16'(int'(x) / int'(y));
         end
         3'd5: begin
            e.lat = 17;
            if (y == 0) begin e.res = x; e.dbz = 1'b1; end
            else e.res = 16'(int'(x) % int'(y));
         end
         default: e.ill = 1'b1;
      endcase
      return e;
   endfunction

   // Presents an operation and returns once the accept edge has passed.
   task automatic issue(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y, output bit ok);
      int n = 0;
      ok = 1'b1;
      in_valid = 1'b1; op = o; a = x; b = y;
      while (!in_ready && n < 40) begin cyc(); n++; end
      if (!in_ready) begin
         check_eq("in_ready_wait", 0, 1);
         in_valid = 1'b0;
         ok = 1'b0;
         return;
      end
      cyc();
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); op = 3'($urandom);
   endtask

   task automatic do_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y, input int hold);
      exp_t        e;
      bit          ok;
      int          lat;
      logic [15:0] held;
      e = model(o, x, y);
      issue(o, x, y, ok);
      if (!ok) return;
      lat = 1;
      while (!out_valid && lat < 60) begin cyc(); lat++; end
      check_eq("latency", lat, e.lat);
      check_eq("result", result, e.res);
      check_eq("Z", Z, e.res == 16'h0);
      check_eq("N", N, e.res[15]);
      check_eq("V", V, e.v);
      check_eq("dbz", dbz, e.dbz);
      check_eq("illegal", illegal, e.ill);
      held = result;
      in_valid = (hold > 0);
      for (int i = 0; i < hold; i++) begin
         cyc();
         check_eq("bp_valid", out_valid, 1);
         check_eq("bp_in_ready", in_ready, 0);
         check_eq("bp_result", result, held);
      end
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      in_valid = 1'b0;
      check_eq("release_valid", out_valid, 0);
      check_eq("release_in_ready", in_ready, 1);
   endtask

   initial begin
      bit          ok;
      logic [2:0]  ro;
      logic [15:0] ra, rb;
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; op = '0;
      cyc(); cyc();
      check_eq("rst_in_ready", in_ready, 0);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_result", result, 0);
      check_eq("rst_flags", {Z, N, V, dbz, illegal}, 0);
      reset = 1'b1;
      cyc();
      check_eq("post_rst_in_ready", in_ready, 1);

      do_op(3'd0, 16'h7FFF, 16'h0001, 0);
      do_op(3'd2, 16'h0005, 16'h0005, 0);
      do_op(3'd3, 16'h0123, 16'h0045, 0);
      do_op(3'd3, 16'h0100, 16'h0100, 0);
      do_op(3'd4, 16'h03E8, 16'h0007, 0);
      do_op(3'd5, 16'h03E8, 16'h0007, 0);
      do_op(3'd4, 16'h1234, 16'h0000, 0);
      do_op(3'd5, 16'h1234, 16'h0000, 5);
      do_op(3'd1, 16'hF0F0, 16'h3C3C, 0);
      do_op(3'd6, 16'h1111, 16'h2222, 0);

      // Flush during BUSY cycle 8 of a MUL.
      issue(3'd3, 16'h00FF, 16'h00FF, ok);
      for (int i = 0; i < 7; i++) cyc();
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      check_eq("flush_out_valid", out_valid, 0);
      check_eq("flush_in_ready", in_ready, 1);
      do_op(3'd0, 16'h0002, 16'h0003, 0);

      // Reset asserted mid-BUSY of a DIVU.
      issue(3'd4, 16'hABCD, 16'h0013, ok);
      for (int i = 0; i < 4; i++) cyc();
      reset = 1'b0;
      #1;
      check_eq("rst_mid_in_ready", in_ready, 0);
      cyc();
      check_eq("rst_mid_out_valid", out_valid, 0);
      check_eq("rst_mid_result", result, 0);
      check_eq("rst_mid_flags", {Z, N, V, dbz, illegal}, 0);
      check_eq("rst_mid_in_ready2", in_ready, 0);
      reset = 1'b1;
      cyc();
      check_eq("rst_rel_in_ready", in_ready, 1);
      do_op(3'd7, 16'h5555, 16'hAAAA, 0);

      for (int t = 0; t < 200; t++) begin
         ro = 3'($urandom_range(0, 7));
         ra = 16'($urandom);
         rb = 16'($urandom);
         if ($urandom_range(0, 7) == 0) rb = '0;
         else if ($urandom_range(0, 3) == 0) rb = 16'($urandom_range(1, 15));
         do_op(ro, ra, rb, $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
